// File: rtl/modexp_pkg.sv
// Shared constants and state encoding for the modular-exponentiation initiator.
package modexp_pkg;

  localparam int OPW   = 128;
  localparam int IDX_W = 7;

  // Modulus used by the companion multiplier; the initiator never reduces by itself.
  localparam logic [OPW-1:0] P = 128'd170141183460469231731687303715885907969;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SQR_REQ,
    S_SQR_WAIT,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/modexp_initiator.sv
// Left-to-right square-and-multiply sequencer; drives an external A*B mod P multiplier.
module modexp_initiator
  import modexp_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [OPW-1:0] base,
  input  logic [OPW-1:0] exponent,
  output logic           busy,
  output logic           done,
  output logic [OPW-1:0] result,
  output logic           mul_in_valid,
  output logic [OPW-1:0] mul_A,
  output logic [OPW-1:0] mul_B,
  input  logic           mul_out_valid,
  input  logic [OPW-1:0] mul_C
);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_dec;
  logic [OPW-1:0]   r_R, w_R_nxt;
  logic [OPW-1:0]   r_base, r_exp, r_result;
  logic             w_load, w_bit, w_idx0;

  assign w_bit     = r_exp[r_idx];
  assign w_idx0    = (r_idx == '0);
  assign w_idx_dec = r_idx - 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_R_nxt     = r_R;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_load      = 1'b1;
        w_idx_nxt   = IDX_W'(OPW - 1);
        w_state_nxt = S_SCAN;
      end
      // Leading zeros cost one cycle each; the first 1 seeds R with base.
      S_SCAN: begin
        if (w_bit) begin
          w_R_nxt = r_base;
          if (w_idx0) w_state_nxt = S_DONE;
          else begin
            w_idx_nxt   = w_idx_dec;
            w_state_nxt = S_SQR_REQ;
          end
        end else if (w_idx0) begin
          w_R_nxt     = OPW'(1);
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt = w_idx_dec;
        end
      end
      S_SQR_REQ: w_state_nxt = S_SQR_WAIT;
      S_SQR_WAIT: if (mul_out_valid) begin
        w_R_nxt = mul_C;
        if (w_bit)       w_state_nxt = S_MUL_REQ;
        else if (w_idx0) w_state_nxt = S_DONE;
        else begin
          w_idx_nxt   = w_idx_dec;
          w_state_nxt = S_SQR_REQ;
        end
      end
      S_MUL_REQ: w_state_nxt = S_MUL_WAIT;
      S_MUL_WAIT: if (mul_out_valid) begin
        w_R_nxt = mul_C;
        if (w_idx0) w_state_nxt = S_DONE;
        else begin
          w_idx_nxt   = w_idx_dec;
          w_state_nxt = S_SQR_REQ;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_R      <= '0;
      r_base   <= '0;
      r_exp    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_R     <= w_R_nxt;
      if (w_load) begin
        r_base <= base;
        r_exp  <= exponent;
      end
      // Loaded on entry to DONE so it is valid alongside the done pulse.
      if (w_state_nxt == S_DONE) r_result <= w_R_nxt;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign result       = r_result;
  assign mul_in_valid = (r_state == S_SQR_REQ) || (r_state == S_MUL_REQ);
  assign mul_A        = mul_in_valid ? r_R : '0;
  assign mul_B        = (r_state == S_SQR_REQ) ? r_R :
                        (r_state == S_MUL_REQ) ? r_base : '0;

endmodule

// File: tb/tb_modexp_initiator.sv
// Scoreboard bench for modexp_initiator with a behavioural A*B mod P multiplier.
module tb_modexp_initiator;

  localparam logic [127:0] PM = 128'd170141183460469231731687303715885907969;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic [127:0] base, exponent;
  logic         busy, done, mul_in_valid, mul_out_valid;
  logic [127:0] result, mul_A, mul_B, mul_C;

  modexp_initiator dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base(base), .exponent(exponent),
    .busy(busy), .done(done), .result(result),
    .mul_in_valid(mul_in_valid), .mul_A(mul_A), .mul_B(mul_B),
    .mul_out_valid(mul_out_valid), .mul_C(mul_C)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] res;
    longint       cyc;
    int           np;
  } exp_t;

  exp_t   sbq[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     done_seen = 0;
  longint cyc = 0;
  int     mul_delay = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [127:0] mulmod(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] prod;
    prod = {128'd0, a} * {128'd0, b};
    return 128'(prod % {128'd0, PM});
  endfunction

  // Multiplier model: answers mul_delay cycles after the zero-stall slot; ignores reset
  // so a response can still arrive after the requester was aborted.
  int           pend = 0;
  logic [127:0] c_pend;
  initial begin mul_out_valid = 1'b0; mul_C = '0; end
  always @(posedge clock) begin
    mul_out_valid <= 1'b0;
    if (mul_in_valid) begin
      if (mul_delay == 0) begin
        mul_out_valid <= 1'b1;
        mul_C         <= mulmod(mul_A, mul_B);
        pend          <= 0;
      end else begin
        c_pend <= mulmod(mul_A, mul_B);
        pend   <= mul_delay;
      end
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        mul_out_valid <= 1'b1;
        mul_C         <= c_pend;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  int pcnt = 0;
  bit operr = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      pcnt  = 0;
      operr = 1'b0;
    end else begin
      if (mul_in_valid) pcnt++;
      else if (mul_A != '0 || mul_B != '0) operr = 1'b1;
      if (done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          exp_t x;
          x = sbq.pop_front();
          chk("result", result, x.res);
          chk("latency_cycle", 128'(cyc), 128'(x.cyc));
          chk("mul_pulses", 128'(pcnt), 128'(x.np));
          chk("idle_operands_zero", 128'(operr), 128'd0);
        end
        pcnt  = 0;
        operr = 1'b0;
        done_seen++;
      end
    end
  end

  // restart_at > 0 pulses start again (different operands) that many cycles into the run.
  task automatic run_op(input logic [127:0] b, input logic [127:0] e, input logic [127:0] r,
                        input int n, input int np, input int restart_at);
    exp_t x;
    int   seen0;
    @(negedge clock);
    base = b; exponent = e; start = 1'b1;
    x.res = r; x.cyc = cyc + 1 + n; x.np = np;
    sbq.push_back(x);
    seen0 = done_seen;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'd1);
    for (int k = 1; k < n + 64 && done_seen == seen0; k++) begin
      @(negedge clock);
      start = (restart_at != 0 && k == restart_at);
      if (start) begin base = 128'd2; exponent = 128'd10; end
      #1;
    end
    start = 1'b0;
    chk("done_within_budget", 128'(done_seen - seen0), 128'd1);
    @(negedge clock);
    chk("busy_after_done", 128'(busy), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    reset_n = 1'b0; start = 1'b0; base = '0; exponent = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_mul_in_valid", 128'(mul_in_valid), 128'd0);
    chk("rst_result", result, 128'd0);
    chk("rst_mul_A", mul_A, 128'd0);
    chk("rst_mul_B", mul_B, 128'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Latency N = (128-m) + 2m + 2*popcount(e[m-1:0]); 128 when e has no 1 above bit 0.
    run_op(128'd5, 128'd0,  128'd1,           128, 0, 0);
    run_op(128'd5, 128'd1,  128'd5,           128, 0, 0);
    run_op(128'd7, 128'd13, 128'd96889010407, 135, 5, 0);
    mul_delay = 3;
    run_op(128'd3, 128'd2,  128'd9,           132, 1, 0);
    mul_delay = 0;
    run_op(PM - 128'd1, 128'd2, 128'd1,       129, 1, 0);
    run_op(PM - 128'd1, 128'd3, PM - 128'd1,  131, 2, 0);
    run_op(128'd1, {128{1'b1}}, 128'd1,       509, 254, 0);
    run_op(128'd7, 128'd13, 128'd96889010407, 135, 5, 5);

    // Abort during MUL_WAIT: second request of e=3 is the multiply step.
    mul_delay = 20;
    @(negedge clock);
    base = 128'd5; exponent = 128'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    np = 0;
    for (int k = 0; k < 400 && np < 2; k++) begin
      @(negedge clock);
      if (mul_in_valid) np++;
    end
    chk("reach_mul_req", 128'(np), 128'd2);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_result", result, 128'd0);
    chk("abort_mul_in_valid", 128'(mul_in_valid), 128'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    mul_delay = 0;
    run_op(128'd2, 128'd10, 128'd1024, 133, 4, 0);

    repeat (200) @(negedge clock);
    chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
